// File: rtl/demux2_seq.sv
// Registered 1-to-2 demultiplexer: steers one sample stream to channel A or B,
// with the select taken from a pin or from an auto-alternating slot counter.

module demux2_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             vld
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= we;
      if (we) dout <= din;
    end
  end
endmodule

module demux2_seq #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             auto_en,
  input  logic             sl,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             a_valid,
  output logic             b_valid,
  output logic             cur_sel,
  output logic             slot_done
);
  localparam int CW = 16;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt, base_cnt;
  logic          asel, auto_q;
  logic          enter, base_asel, esel, wrap;
  logic [1:0]              ch_we;
  logic [1:0]              ch_vld;
  logic [1:0][WIDTH-1:0]   ch_dout;

  // On the 0->1 auto edge the slot restarts from sl in the same cycle, so the
  // counter logic works from these "base" values rather than the raw registers.
  always_comb begin
    enter     = auto_en & ~auto_q;
    base_cnt  = enter ? '0 : cnt;
    base_asel = enter ? sl : asel;
    esel      = auto_en ? base_asel : sl;
    wrap      = auto_en & din_valid & (base_cnt == LAST);
    ch_we     = {din_valid & esel, din_valid & ~esel};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      asel   <= 1'b0;
      auto_q <= 1'b0;
    end else begin
      auto_q <= auto_en;
      if (auto_en) begin
        if (wrap) begin
          cnt  <= '0;
          asel <= ~base_asel;
        end else if (din_valid) begin
          cnt  <= base_cnt + 16'd1;
          asel <= base_asel;
        end else begin
          cnt  <= base_cnt;
          asel <= base_asel;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel   <= 1'b0;
      slot_done <= 1'b0;
    end else begin
      slot_done <= wrap;
      if (din_valid) cur_sel <= esel;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    demux2_ch #(.WIDTH(WIDTH)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (ch_we[g]),
      .din  (din),
      .dout (ch_dout[g]),
      .vld  (ch_vld[g])
    );
  end

  assign out_a   = ch_dout[0];
  assign out_b   = ch_dout[1];
  assign a_valid = ch_vld[0];
  assign b_valid = ch_vld[1];
endmodule

// File: tb/tb_demux2_seq.sv
// Bench for demux2_seq: two instances (PERIOD 4 and 3) share one directed
// stimulus; a per-instance behavioural model is compared every cycle.

module tb_demux2_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0, auto_en = 1'b0, sl = 1'b0;

  logic [7:0] oa4, ob4, oa3, ob3;
  logic       av4, bv4, cs4, sd4, av3, bv3, cs3, sd3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  demux2_seq #(.WIDTH(8), .PERIOD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .auto_en(auto_en), .sl(sl),
    .out_a(oa4), .out_b(ob4), .a_valid(av4), .b_valid(bv4), .cur_sel(cs4), .slot_done(sd4));

  demux2_seq #(.WIDTH(8), .PERIOD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .auto_en(auto_en), .sl(sl),
    .out_a(oa3), .out_b(ob3), .a_valid(av3), .b_valid(bv3), .cur_sel(cs3), .slot_done(sd3));

  // Model: samples in the current slot, the slot's channel, and the mode seen last cycle.
  typedef struct {
    logic [7:0] oa, ob;
    logic av, bv, cs, sd;
    int   slot_pos;
    logic slot_ch;
    logic was_auto;
  } mstate_t;

  localparam mstate_t MRST = '{oa: 8'h0, ob: 8'h0, av: 1'b0, bv: 1'b0, cs: 1'b0, sd: 1'b0,
                               slot_pos: 0, slot_ch: 1'b0, was_auto: 1'b0};

  function automatic mstate_t step(mstate_t s, int period, logic [7:0] d, logic v,
                                   logic ae, logic s_l);
    mstate_t n;
    logic    ch;
    n = s;
    n.av = 1'b0; n.bv = 1'b0; n.sd = 1'b0;
    n.was_auto = ae;
    if (ae && !s.was_auto) begin
      n.slot_pos = 0;
      n.slot_ch  = s_l;
    end
    ch = ae ? n.slot_ch : s_l;
    if (v) begin
      if (ch) begin n.ob = d; n.bv = 1'b1; end
      else    begin n.oa = d; n.av = 1'b1; end
      n.cs = ch;
      if (ae) begin
        n.slot_pos = n.slot_pos + 1;
        if (n.slot_pos == period) begin
          n.slot_pos = 0;
          n.slot_ch  = ~n.slot_ch;
          n.sd       = 1'b1;
        end
      end
    end
    return n;
  endfunction

  mstate_t m4 = MRST, m3 = MRST;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= MRST;
      m3 <= MRST;
    end else begin
      m4 <= step(m4, 4, din, din_valid, auto_en, sl);
      m3 <= step(m3, 3, din, din_valid, auto_en, sl);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({oa4, ob4, av4, bv4, cs4, sd4} !== {m4.oa, m4.ob, m4.av, m4.bv, m4.cs, m4.sd}) begin
        errors++;
        $display("FAIL model_p4 t=%0t got a=%h b=%h av=%b bv=%b cs=%b sd=%b want a=%h b=%h av=%b bv=%b cs=%b sd=%b",
                 $time, oa4, ob4, av4, bv4, cs4, sd4, m4.oa, m4.ob, m4.av, m4.bv, m4.cs, m4.sd);
      end
      checks++;
      if ({oa3, ob3, av3, bv3, cs3, sd3} !== {m3.oa, m3.ob, m3.av, m3.bv, m3.cs, m3.sd}) begin
        errors++;
        $display("FAIL model_p3 t=%0t got a=%h b=%h av=%b bv=%b cs=%b sd=%b want a=%h b=%h av=%b bv=%b cs=%b sd=%b",
                 $time, oa3, ob3, av3, bv3, cs3, sd3, m3.oa, m3.ob, m3.av, m3.bv, m3.cs, m3.sd);
      end
      checks++;
      if ((av4 & bv4) | (av3 & bv3)) begin
        errors++;
        $display("FAIL both_valid t=%0t got av4=%b bv4=%b av3=%b bv3=%b want not both", $time, av4, bv4, av3, bv3);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; on return the outputs reflect this cycle's sample.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ae, input logic s);
    din_valid = v; din = d; auto_en = ae; sl = s;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] t;
    repeat (2) @(negedge clk);
    chk("reset_p4", {16'h0, oa4, ob4} | {28'h0, av4, bv4, cs4, sd4}, 32'h0);
    chk("reset_p3", {16'h0, oa3, ob3} | {28'h0, av3, bv3, cs3, sd3}, 32'h0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Manual routing
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    chk("man_a", {oa4, ob4, av4, bv4}, {16'h1100, 2'b10});
    cyc(1'b1, 8'h22, 1'b0, 1'b1);
    chk("man_b", {oa4, ob4, av4, bv4, cs4}, {16'h1122, 3'b011});

    // Idle hold with toggling din/sl
    for (int i = 0; i < 10; i++) begin
      t = 8'(i * 37);
      cyc(1'b0, t, 1'b0, t[0]);
    end
    chk("idle_hold", {oa4, ob4, av4, bv4, cs4}, {16'h1122, 3'b001});

    // Auto slots, continuous valid 1..12
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(i), 1'b1, 1'b0);
      if (i == 3)  chk("p3_slot_done_3", {oa3, sd3}, {8'd3, 1'b1});
      if (i == 4)  chk("p4_slot_a_end", {oa4, av4, sd4}, {8'd4, 2'b11});
      if (i == 5)  chk("p4_slot_b_start", {ob4, bv4, sd4}, {8'd5, 2'b10});
      if (i == 8)  chk("p4_slot_b_end", {ob4, bv4, sd4}, {8'd8, 2'b11});
      if (i == 12) chk("p4_slot_a2_end", {oa4, ob4, av4, sd4}, {16'h0C08, 2'b11});
    end

    // Gapped auto: restart slot, alternate valid
    cyc(1'b0, 8'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
      if (i == 3) chk("p3_gap_toggle", {oa3, av3, sd3}, {8'h33, 2'b11});
      if (i == 4) chk("p3_gap_next_b", {ob3, bv3, sd3}, {8'h34, 2'b10});
      cyc(1'b0, 8'hEE, 1'b1, 1'b1);
      if (i == 2) chk("p3_gap_idle", {av3, bv3, sd3}, 3'b000);
    end

    // Mode switch mid-slot
    cyc(1'b0, 8'h0, 1'b0, 1'b0);
    cyc(1'b1, 8'h41, 1'b1, 1'b0);
    cyc(1'b1, 8'h42, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b1);
      chk("man_override_b", {bv4, av4}, 2'b10);
    end
    chk("man_override_hold", {oa4, ob4}, 16'h4255);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
      if (i == 4) chk("reenter_slot_end", {oa4, av4, sd4}, {8'h64, 2'b11});
      if (i == 5) chk("reenter_next_b", {ob4, bv4, cs4}, {8'h65, 2'b11});
    end

    // Reset mid-slot B, asynchronous
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_p4", {oa4, ob4, av4, bv4, cs4, sd4}, 20'h0);
    chk("async_reset_p3", {oa3, ob3, av3, bv3, cs3, sd3}, 20'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
      if (i <= 4) chk("post_reset_a", {av4, bv4}, 2'b10);
      if (i == 4) chk("post_reset_done", {oa4, sd4}, {8'h74, 1'b1});
      if (i == 5) chk("post_reset_b", {ob4, bv4}, {8'h75, 1'b1});
    end

    cyc(1'b0, 8'h0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux2_seq.md
# demux2_seq

Registered 1-to-2 demultiplexer: the receive-side counterpart of the team's `mux2` selector. A single input stream is steered to channel A or channel B, and each channel holds its last value between updates. The select comes either from an external pin or from an internal slot counter that alternates channels every `PERIOD` accepted samples. The block sits after a shared/time-multiplexed link and restores the two original streams.

## Interface
- `WIDTH`, 8: data width of `din`, `out_a`, `out_b`.
- `PERIOD`, 50: accepted samples per channel slot in auto mode; legal range 1..65535.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `din`  input  WIDTH  input sample.
- `din_valid`  input  1  `din` is valid this cycle; sample is accepted when high.
- `auto_en`  input  1  1 = internal slot counter drives the select; 0 = `sl` drives it.
- `sl`  input  1  manual select (0 → A, 1 → B); used only when `auto_en`=0.
- `out_a`  output  WIDTH  channel A data, held between updates.
- `out_b`  output  WIDTH  channel B data, held between updates.
- `a_valid`  output  1  one-cycle pulse: `out_a` updated this cycle.
- `b_valid`  output  1  one-cycle pulse: `out_b` updated this cycle.
- `cur_sel`  output  1  select applied to the most recently accepted sample.
- `slot_done`  output  1  one-cycle pulse: auto slot completed and the select toggled.

## Operation
- Effective select `esel`:
  - `auto_en`=0: `esel` = `sl`.
  - `auto_en`=1: `esel` = internal register `asel`.
- On an accepted sample (`din_valid`=1):
  - `esel`=0: `out_a` ← `din`, `a_valid`=1.
  - `esel`=1: `out_b` ← `din`, `b_valid`=1.
  - `cur_sel` ← `esel`.
  - The non-selected output keeps its value.
- No accept (`din_valid`=0): both valids 0; all data outputs and `cur_sel` hold.
- Auto slot counter `cnt`, 16 bits, counts accepted samples only, and only while `auto_en`=1:
  - If `cnt` = `PERIOD`-1 on an accept: `cnt` ← 0, `asel` ← ~`asel`, `slot_done`=1 in the same cycle as that sample's valid pulse.
  - Otherwise: `cnt` ← `cnt`+1.
  - That last sample still goes to the old channel; the next accepted sample goes to the new channel.
- Entering auto mode (`auto_en` sampled 0 → 1, detected with a registered copy of `auto_en`):
  - `cnt` ← 0 and `asel` ← `sl`, so the channel does not jump.
  - A sample accepted in that same cycle uses `sl` and counts as sample 1 of the slot (`cnt` ← 1, or a toggle if `PERIOD`=1).
- Leaving auto mode: `cnt` and `asel` freeze, and `sl` takes effect immediately.
- `PERIOD`=1: the select toggles on every accepted sample, giving strict A,B,A,B alternation.
- Reset values: `out_a`=0, `out_b`=0, `a_valid`=0, `b_valid`=0, `cur_sel`=0, `slot_done`=0; internally `cnt`=0, `asel`=0, registered `auto_en`=0.
- Reset mid-slot discards `cnt`. After release, the first accepted sample in auto mode starts a fresh slot on channel A, unless `auto_en` is high at release: the 0→1 edge rule then loads `asel` ← `sl`.

## Timing
- Latency: 1 cycle. `din`/`din_valid` at edge N appear on `out_*`/`*_valid` after edge N.
- `a_valid` and `b_valid` are never high in the same cycle.
- `slot_done` coincides with the valid pulse of the slot's last sample.
- Throughput: one sample per cycle, with no stall or backpressure.
- `sl` is sampled only on cycles with `din_valid`=1, so glitches on idle cycles have no effect.
- Asynchronous reset clears all outputs immediately, without waiting for a clock edge; the first update after release occurs on the first rising edge with `rst_n`=1.

## Test plan
- **Manual routing.** `auto_en`=0; `sl`=0, `din`=0x11 valid → `out_a`=0x11, `a_valid` pulse, `out_b`=0. Then `sl`=1, `din`=0x22 → `out_b`=0x22, `out_a` holds 0x11.
- **Idle hold.** `din_valid`=0 for 10 cycles while `din` and `sl` toggle every cycle → outputs unchanged, both valids 0.
- **Auto slots.** `PERIOD`=4, `auto_en`=1, continuous valid with `din`=1..12 → A receives 1–4, B receives 5–8, A receives 9–12; `slot_done` with samples 4, 8 and 12.
- **Gapped auto.** `PERIOD`=3; alternate `din_valid` 1/0 → the counter advances only on valid cycles, and the toggle occurs after the third accepted sample, not after the third cycle.
- **Mode switch.** In auto mode mid-slot (`cnt`=2), drop `auto_en` for 5 samples with `sl`=1 → all go to B. Re-raise `auto_en` with `sl`=0 → slot restarts on A with a full `PERIOD` samples.
- **Reset mid-slot.** Assert `rst_n`=0 asynchronously during auto slot B → outputs clear immediately. After release, with `auto_en` high and `sl`=0 → A receives the next `PERIOD` samples.
